exc_sequencer: RTL and testbench
================================

// Module: exc_sequencer
// PURPOSE
//  Sequences exception entry, interrupt entry and ERTN return for the 5-stage pipeline around the CSR file.
//  Arbitrates the MEM-stage trap sources (interrupt, synchronous exception, ERTN) and drives the CSR's
//  exc_sig/Ecode/EsubCode/PC/ERTN inputs for exactly one cycle.
//  Flushes the pipeline, redirects fetch, then holds fetch until the CSR state has settled.
//  Sits between the MEM stage, the CSR block and the IF-stage PC mux.
// PARAMETERS
//  HOLD_CYCLES  2   fetch-hold cycles after redirect; allowed range 1..15
//  CNT_W        32  width of each statistics counter
// PORTS
//  clk            in   1   clock
//  rst            in   1   asynchronous, active-high reset
//  int_req        in   1   CSR INT output (already masked by CRMD.IE), level
//  mem_valid      in   1   MEM holds a valid, non-flushed instruction
//  mem_stall      in   1   MEM cannot retire this cycle (load/store pending)
//  mem_exc        in   1   MEM instruction carries a synchronous exception
//  mem_ecode      in   6   Ecode of that exception
//  mem_esubcode   in   9   EsubCode of that exception
//  mem_ertn       in   1   MEM instruction is ERTN
//  mem_pc         in   32  PC of the MEM instruction
//  eentry         in   32  CSR EENTRY_out (WB-forwarded)
//  era            in   32  CSR ERA_out (MEM/WB-forwarded)
//  csr_exc_sig    out  1   one-cycle trap-entry strobe to CSR
//  csr_ecode      out  6   Ecode to CSR
//  csr_esubcode   out  9   EsubCode to CSR
//  csr_pc         out  32  PC written to ERA by CSR
//  csr_ertn       out  1   one-cycle ERTN strobe to CSR
//  flush          out  1   kill IF/ID/EX/MEM; WB is never killed
//  redirect_valid out  1   load redirect_pc into the fetch PC
//  redirect_pc    out  32  fetch target
//  fetch_hold     out  1   IF must not issue
//  busy           out  1   FSM is not in IDLE
//  n_exc          out  CNT_W  synchronous exceptions taken (wraps)
//  n_int          out  CNT_W  interrupts taken (wraps)
//  n_ertn         out  CNT_W  ERTNs executed (wraps)
// BEHAVIOUR
//  Reset: all outputs are 0, including the counters; state = IDLE.
//  Reset mid-sequence aborts the sequence immediately. No strobe is replayed after reset.
//  States: IDLE -> COMMIT -> REDIRECT -> HOLD -> IDLE.
//  Trigger condition (IDLE only): mem_valid & ~mem_stall & (int_req | mem_exc | mem_ertn).
//   With mem_stall=1 nothing is taken. Sources are re-evaluated every cycle and are never latched early.
//  Priority when several sources are true in the same cycle: int_req > mem_exc > mem_ertn.
//  COMMIT (1 cycle), Moore outputs from registered selection:
//   - Interrupt: csr_exc_sig=1, Ecode=0x00, EsubCode=0. The MEM instruction is not executed and
//     csr_pc=mem_pc.
//   - Exception: csr_exc_sig=1, Ecode and EsubCode are the captured mem_ecode/mem_esubcode,
//     csr_pc = captured mem_pc.
//   - ERTN: csr_ertn=1; Ecode, EsubCode and csr_pc are driven 0.
//   - flush=1. The target register captures eentry (traps) or era (ERTN) at this cycle's inputs.
//   - The matching statistics counter increments by 1 at the end of COMMIT, wrapping modulo 2^CNT_W.
//  REDIRECT (1 cycle): redirect_valid=1, redirect_pc=target, flush=1, fetch_hold=1.
//   redirect_pc[1:0] is forced to 0. For traps, bits [5:0] are also forced to 0.
//  HOLD: fetch_hold=1 for HOLD_CYCLES cycles using a down-counter, then return to IDLE.
//   No trigger is accepted during HOLD, so an interrupt cannot fire before CRMD.IE/PLV are visible.
//  Timing: latency from trigger-cycle edge to csr strobe is 1 cycle, to redirect_valid is 2 cycles.
//   A trap occupies 3 + HOLD_CYCLES cycles in total.
//  busy=1 in every state except IDLE. All mem_* inputs and int_req are ignored while busy.
//  In all other states csr_exc_sig, csr_ertn, flush and redirect_valid are 0.
//  csr_exc_sig and csr_ertn are never both 1.
//  redirect_pc holds its last value when redirect_valid=0.
// TESTING
//  1. Reset; mem_valid=1, mem_exc=1, ecode=0x0B, pc=0x1C00_0100, eentry=0x1C00_8000 ->
//     +1 csr_exc_sig with Ecode 0x0B and csr_pc 0x1C00_0100; +2 redirect to 0x1C00_8000; n_exc=1.
//  2. int_req, mem_exc and mem_ertn all 1 in one cycle -> interrupt is taken (Ecode 0, csr_pc=mem_pc);
//     csr_ertn stays 0; n_int=1, n_exc=0.
//  3. ERTN with era=0x1C00_0104 -> +1 csr_ertn, +2 redirect 0x1C00_0104.
//     int_req=1 throughout HOLD is ignored and taken on the first IDLE cycle afterwards.
//  4. mem_exc=1 with mem_stall=1 for 3 cycles -> no strobe. Stall drops -> COMMIT on the next cycle.
//  5. rst asserted during REDIRECT -> all outputs 0 immediately; after release, IDLE with busy=0.
//  6. Preload n_exc=2^CNT_W-1 by forcing it, then take an exception -> n_exc wraps to 0.

Source files
------------

// File: rtl/exc_sequencer.sv
// Trap/ERTN sequencer between the MEM stage, the CSR file and the fetch PC mux.
// Commits one trap or ERTN at a time, flushes, redirects fetch, then holds fetch while CSR state settles.
module exc_sequencer #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             int_req,
  input  logic             mem_valid,
  input  logic             mem_stall,
  input  logic             mem_exc,
  input  logic [5:0]       mem_ecode,
  input  logic [8:0]       mem_esubcode,
  input  logic             mem_ertn,
  input  logic [31:0]      mem_pc,
  input  logic [31:0]      eentry,
  input  logic [31:0]      era,
  output logic             csr_exc_sig,
  output logic [5:0]       csr_ecode,
  output logic [8:0]       csr_esubcode,
  output logic [31:0]      csr_pc,
  output logic             csr_ertn,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             fetch_hold,
  output logic             busy,
  output logic [CNT_W-1:0] n_exc,
  output logic [CNT_W-1:0] n_int,
  output logic [CNT_W-1:0] n_ertn
);

  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT, HOLD} state_t;
  typedef enum logic [1:0] {SRC_INT, SRC_EXC, SRC_ERTN} src_t;

  state_t     state, state_next;
  src_t       src;
  logic [5:0] ecode;
  logic [8:0] esubcode;
  logic [31:0] pc;
  logic [31:0] target;
  logic [3:0] hold_cnt;
  logic [CNT_W-1:0] exc_cnt, int_cnt, ertn_cnt;
  logic       trigger;

  assign trigger = mem_valid & ~mem_stall & (int_req | mem_exc | mem_ertn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (trigger) state_next = COMMIT;
      COMMIT:   state_next = REDIRECT;
      REDIRECT: state_next = HOLD;
      HOLD:     if (hold_cnt == 4'd0) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Capture the winning source in the trigger cycle; target is taken from the CSR outputs during COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src      <= SRC_INT;
      ecode    <= 6'd0;
      esubcode <= 9'd0;
      pc       <= 32'd0;
      target   <= 32'd0;
      hold_cnt <= 4'd0;
      exc_cnt  <= '0;
      int_cnt  <= '0;
      ertn_cnt <= '0;
    end else begin
      if (state == IDLE && trigger) begin
        src      <= int_req ? SRC_INT : (mem_exc ? SRC_EXC : SRC_ERTN);
        ecode    <= mem_ecode;
        esubcode <= mem_esubcode;
        pc       <= mem_pc;
      end
      if (state == COMMIT) begin
        if (src == SRC_ERTN) begin
          target   <= {era[31:2], 2'b00};
          ertn_cnt <= ertn_cnt + CNT_W'(1);
        end else begin
          target <= {eentry[31:6], 6'b000000};
          if (src == SRC_INT) int_cnt <= int_cnt + CNT_W'(1);
          else                exc_cnt <= exc_cnt + CNT_W'(1);
        end
      end
      if (state == REDIRECT)
        hold_cnt <= 4'(HOLD_CYCLES - 1);
      else if (state == HOLD && hold_cnt != 4'd0)
        hold_cnt <= hold_cnt - 4'd1;
    end
  end

  always_comb begin
    csr_exc_sig    = 1'b0;
    csr_ertn       = 1'b0;
    csr_ecode      = 6'd0;
    csr_esubcode   = 9'd0;
    csr_pc         = 32'd0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    fetch_hold     = 1'b0;
    case (state)
      COMMIT: begin
        flush = 1'b1;
        if (src == SRC_ERTN) begin
          csr_ertn = 1'b1;
        end else begin
          csr_exc_sig = 1'b1;
          csr_pc      = pc;
          if (src == SRC_EXC) begin
            csr_ecode    = ecode;
            csr_esubcode = esubcode;
          end
        end
      end
      REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        fetch_hold     = 1'b1;
      end
      HOLD:    fetch_hold = 1'b1;
      default: fetch_hold = 1'b0;
    endcase
  end

  assign busy        = (state != IDLE);
  assign redirect_pc = target;
  assign n_exc       = exc_cnt;
  assign n_int       = int_cnt;
  assign n_ertn      = ertn_cnt;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed table-driven bench for exc_sequencer plus hand-written multi-cycle corner sequences.
module tb_exc_sequencer;
  localparam int HOLD  = 2;
  localparam int CNT_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_req, mem_valid, mem_stall, mem_exc, mem_ertn;
  logic [5:0]  mem_ecode;
  logic [8:0]  mem_esubcode;
  logic [31:0] mem_pc, eentry, era;
  logic        csr_exc_sig, csr_ertn, flush, redirect_valid, fetch_hold, busy;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic [31:0] csr_pc, redirect_pc;
  logic [CNT_W-1:0] n_exc, n_int, n_ertn;

  always #5 clk = ~clk;

  exc_sequencer #(.HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .mem_valid(mem_valid), .mem_stall(mem_stall),
    .mem_exc(mem_exc), .mem_ecode(mem_ecode), .mem_esubcode(mem_esubcode), .mem_ertn(mem_ertn),
    .mem_pc(mem_pc), .eentry(eentry), .era(era), .csr_exc_sig(csr_exc_sig), .csr_ecode(csr_ecode),
    .csr_esubcode(csr_esubcode), .csr_pc(csr_pc), .csr_ertn(csr_ertn), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_hold(fetch_hold),
    .busy(busy), .n_exc(n_exc), .n_int(n_int), .n_ertn(n_ertn)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] m_exc, m_int, m_ertn;

  typedef struct {
    logic intr, valid, stall, exc, ertn;
    logic [5:0] ecode; logic [8:0] esub;
    logic [31:0] pc, eentry, era;
    int kind;  // 0 none, 1 interrupt, 2 exception, 3 ertn
    logic [5:0] x_ecode; logic [8:0] x_esub;
    logic [31:0] x_pc, x_rpc;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    int_req = 1'b0; mem_valid = 1'b0; mem_stall = 1'b0; mem_exc = 1'b0; mem_ertn = 1'b0;
    mem_ecode = 6'd0; mem_esubcode = 9'd0; mem_pc = 32'd0;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, " n_exc"}, n_exc, m_exc);
    chk({tag, " n_int"}, n_int, m_int);
    chk({tag, " n_ertn"}, n_ertn, m_ertn);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("drain busy", busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 6'h0B,9'h000, 32'h1C00_0100,32'h1C00_8000,32'h0000_0000,
                2, 6'h0B,9'h000, 32'h1C00_0100,32'h1C00_8000};
    vecs[1] = '{1'b1,1'b1,1'b0,1'b1,1'b1, 6'h08,9'h001, 32'h1C00_0200,32'h1C00_8000,32'h1C00_0104,
                1, 6'h00,9'h000, 32'h1C00_0200,32'h1C00_8000};
    vecs[2] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 6'h00,9'h000, 32'h1C00_0300,32'h1C00_8000,32'h1C00_0107,
                3, 6'h00,9'h000, 32'h0000_0000,32'h1C00_0104};
    vecs[3] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 6'h3F,9'h1FF, 32'hFFFF_FFFC,32'h1C00_807F,32'h0000_0000,
                2, 6'h3F,9'h1FF, 32'hFFFF_FFFC,32'h1C00_8040};
    vecs[4] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 6'h09,9'h002, 32'h1C00_0400,32'h0000_1234,32'h1C00_0104,
                2, 6'h09,9'h002, 32'h1C00_0400,32'h0000_1200};
    vecs[5] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 6'h01,9'h000, 32'h1C00_0500,32'h1C00_8000,32'h0000_0000,
                0, 6'h00,9'h000, 32'h0,32'h0};
    vecs[6] = '{1'b0,1'b1,1'b1,1'b1,1'b0, 6'h02,9'h000, 32'h1C00_0600,32'h1C00_8000,32'h0000_0000,
                0, 6'h00,9'h000, 32'h0,32'h0};
    vecs[7] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 6'h03,9'h000, 32'h1C00_0700,32'h1C00_8000,32'h0000_0000,
                0, 6'h00,9'h000, 32'h0,32'h0};

    m_exc = 32'd0; m_int = 32'd0; m_ertn = 32'd0;
    idle_inputs(); eentry = 32'd0; era = 32'd0;
    rst = 1'b1;
    #2;
    chk("reset busy", busy, 1'b0);
    chk("reset exc_sig", csr_exc_sig, 1'b0);
    chk("reset redirect_pc", redirect_pc, 32'd0);
    chk_counters("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Table-driven single transactions
    foreach (vecs[v]) begin
      @(negedge clk);
      int_req = vecs[v].intr; mem_valid = vecs[v].valid; mem_stall = vecs[v].stall;
      mem_exc = vecs[v].exc; mem_ertn = vecs[v].ertn; mem_ecode = vecs[v].ecode;
      mem_esubcode = vecs[v].esub; mem_pc = vecs[v].pc; eentry = vecs[v].eentry; era = vecs[v].era;
      @(negedge clk);
      if (vecs[v].kind == 0) begin
        chk($sformatf("v%0d idle busy", v), busy, 1'b0);
        chk($sformatf("v%0d idle strobes", v), {csr_exc_sig, csr_ertn, flush}, 3'b000);
        idle_inputs();
        continue;
      end
      chk($sformatf("v%0d commit busy", v), busy, 1'b1);
      chk($sformatf("v%0d exc_sig", v), csr_exc_sig, (vecs[v].kind != 3));
      chk($sformatf("v%0d ertn", v), csr_ertn, (vecs[v].kind == 3));
      chk($sformatf("v%0d ecode", v), csr_ecode, vecs[v].x_ecode);
      chk($sformatf("v%0d esubcode", v), csr_esubcode, vecs[v].x_esub);
      chk($sformatf("v%0d csr_pc", v), csr_pc, vecs[v].x_pc);
      chk($sformatf("v%0d commit flush/rv", v), {flush, redirect_valid}, 2'b10);
      case (vecs[v].kind)
        1: m_int++;
        2: m_exc++;
        default: m_ertn++;
      endcase
      idle_inputs();
      @(negedge clk);
      chk($sformatf("v%0d redirect flags", v), {redirect_valid, flush, fetch_hold, csr_exc_sig, csr_ertn}, 5'b11100);
      chk($sformatf("v%0d redirect_pc", v), redirect_pc, vecs[v].x_rpc);
      for (int h = 0; h < HOLD; h++) begin
        @(negedge clk);
        chk($sformatf("v%0d hold%0d flags", v, h), {busy, fetch_hold, redirect_valid, flush}, 4'b1100);
        chk($sformatf("v%0d hold%0d rpc", v, h), redirect_pc, vecs[v].x_rpc);
      end
      @(negedge clk);
      chk($sformatf("v%0d back idle", v), {busy, fetch_hold}, 2'b00);
      chk_counters($sformatf("v%0d", v));
    end

    // ERTN, then an interrupt held high through HOLD is taken only once IDLE is reached
    @(negedge clk);
    mem_valid = 1'b1; mem_ertn = 1'b1; mem_pc = 32'h1C00_0900; era = 32'h1C00_0104; eentry = 32'h1C00_9000;
    @(negedge clk);
    chk("ertn strobe", {csr_ertn, csr_exc_sig}, 2'b10);
    m_ertn++;
    mem_ertn = 1'b0; int_req = 1'b1; mem_pc = 32'h1C00_0A00;
    @(negedge clk);
    chk("ertn redirect_pc", redirect_pc, 32'h1C00_0104);
    for (int h = 0; h < HOLD; h++) begin
      @(negedge clk);
      chk($sformatf("int ignored hold%0d", h), {busy, csr_exc_sig}, 2'b10);
    end
    @(negedge clk);
    chk("int first idle", {busy, csr_exc_sig}, 2'b00);
    @(negedge clk);
    chk("int taken", {csr_exc_sig, csr_ecode}, {1'b1, 6'h00});
    chk("int csr_pc", csr_pc, 32'h1C00_0A00);
    m_int++;
    idle_inputs();
    drain();
    chk_counters("ertn+int");

    // Stall blocks the trigger; release commits on the next cycle
    @(negedge clk);
    mem_valid = 1'b1; mem_exc = 1'b1; mem_stall = 1'b1; mem_ecode = 6'h0B; mem_pc = 32'h1C00_0B00;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("stall%0d", s), {busy, csr_exc_sig}, 2'b00);
    end
    mem_stall = 1'b0;
    @(negedge clk);
    chk("stall release commit", {csr_exc_sig, csr_ecode}, {1'b1, 6'h0B});
    m_exc++;
    idle_inputs();
    drain();
    chk_counters("stall");

    // Reset asserted during REDIRECT aborts at once
    @(negedge clk);
    mem_valid = 1'b1; mem_exc = 1'b1; mem_pc = 32'h1C00_0C00; eentry = 32'h1C00_A000;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    chk("pre-reset redirect", redirect_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid reset flags", {busy, redirect_valid, flush, fetch_hold, csr_exc_sig, csr_ertn}, 6'd0);
    chk("mid reset rpc", redirect_pc, 32'd0);
    m_exc = 32'd0; m_int = 32'd0; m_ertn = 32'd0;
    chk_counters("mid reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post reset idle", {busy, csr_exc_sig, csr_ertn}, 3'b000);

    // Counter wrap from all-ones
    force dut.exc_cnt = '1;
    @(negedge clk);
    release dut.exc_cnt;
    chk("preload n_exc", n_exc, 32'hFFFF_FFFF);
    mem_valid = 1'b1; mem_exc = 1'b1; mem_pc = 32'h1C00_0D00;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    chk("n_exc wrap", n_exc, 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
